// File: rtl/mem_stage_access_ctrl.sv
// MEM-stage initiator for the data memory: byte-addressed loads/stores become
// word-indexed accesses, sub-word stores use read-modify-write, pipeline held via stall.
module mem_stage_access_ctrl #(
   parameter int MEM_WORDS = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [1:0]  mem_size,
   input  logic        mem_unsigned,
   input  logic [31:0] byte_addr,
   input  logic [31:0] store_data,
   output logic        memWrite,
   output logic        memRead,
   output logic [31:0] address,
   output logic [31:0] writedata,
   input  logic [31:0] readdata,
   output logic [31:0] load_data,
   output logic        stall,
   output logic        done,
   output logic        misaligned,
   output logic        bad_addr
);

   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

   state_t      state_q;
   logic [31:0] addr_q;
   logic [1:0]  size_q;
   logic        uns_q;
   logic        store_q;
   logic [31:0] sdata_q;
   logic [31:0] word_q;
   logic [31:0] address_q;
   logic [31:0] load_data_q;

   logic req;
   logic mis;
   logic oob;
   logic accept;

   // Little-endian lane extraction with sign/zero extension.
   function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [1:0]  size,
                                                input logic        uns);
      logic signed [7:0]  b_s;
      logic signed [15:0] h_s;
      logic [31:0]        r;
      b_s = word[{lane, 3'b000} +: 8];
      h_s = word[{lane[1], 4'b0000} +: 16];
      case (size)
         2'b00:   r = uns ? {24'h000000, b_s} : 32'(b_s);
         2'b01:   r = uns ? {16'h0000, h_s} : 32'(h_s);
         default: r = word;
      endcase
      return r;
   endfunction

   // Replace the addressed byte/half lane of the fetched word.
   function automatic logic [31:0] merge_store(input logic [31:0] word,
                                               input logic [31:0] data,
                                               input logic [1:0]  lane,
                                               input logic [1:0]  size);
      logic [31:0] r;
      r = word;
      case (size)
         2'b00:   r[{lane, 3'b000} +: 8] = data[7:0];
         2'b01:   r[{lane[1], 4'b0000} +: 16] = data[15:0];
         default: r = data;
      endcase
      return r;
   endfunction

   always_comb begin
      req    = MemRead | MemWrite;
      mis    = ((mem_size == 2'b01) && byte_addr[0]) ||
               (mem_size[1] && (byte_addr[1:0] != 2'b00));
      oob    = {2'b00, byte_addr[31:2]} >= 32'(MEM_WORDS);
      accept = (state_q == IDLE) && req && !mis && !oob;
   end

   assign memRead    = (state_q == RD);
   assign memWrite   = (state_q == WR);
   assign done       = (state_q == DONE);
   assign stall      = accept || (state_q == RD) || (state_q == WR);
   assign misaligned = (state_q == IDLE) && req && mis;
   assign bad_addr   = (state_q == IDLE) && req && !mis && oob;
   assign address    = address_q;
   assign load_data  = load_data_q;
   // Word stores bypass the buffer; sub-word stores write the merged fetched word.
   assign writedata  = size_q[1] ? sdata_q : merge_store(word_q, sdata_q, addr_q[1:0], size_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         size_q      <= '0;
         uns_q       <= 1'b0;
         store_q     <= 1'b0;
         sdata_q     <= '0;
         word_q      <= '0;
         address_q   <= '0;
         load_data_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  addr_q    <= byte_addr;
                  size_q    <= mem_size;
                  uns_q     <= mem_unsigned;
                  store_q   <= MemWrite;
                  sdata_q   <= store_data;
                  address_q <= {2'b00, byte_addr[31:2]};
                  state_q   <= (MemWrite && mem_size[1]) ? WR : RD;
               end
            end
            RD: begin
               word_q <= readdata;
               if (store_q) begin
                  state_q <= WR;
               end else begin
                  load_data_q <= extract_load(readdata, addr_q[1:0], size_q, uns_q);
                  state_q     <= DONE;
               end
            end
            WR:      state_q <= DONE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/mem_stage_access_ctrl.md
Name: mem_stage_access_ctrl

Overview:
- Initiator side of the data-memory interface, sitting in the MEM stage between the EX/MEM pipeline register and the data memory.
- Converts byte-addressed load/store requests into word-indexed memory accesses on memWrite/memRead/address/writedata/readdata.
- Byte/halfword loads are extracted and extended; byte/halfword stores use read-modify-write.
- Holds the pipeline with stall for the duration of each access.

Parameters:
- MEM_WORDS, 32: number of 32-bit words in the data memory; valid word indices are 0..MEM_WORDS-1.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- MemRead  input  1  load request from EX/MEM
- MemWrite  input  1  store request from EX/MEM
- mem_size  input  2  00 byte, 01 halfword, 10 word, 11 treated as word
- mem_unsigned  input  1  1 = zero-extend sub-word load; 0 = sign-extend
- byte_addr  input  32  byte address (ALU result)
- store_data  input  32  rt value; low byte/half used for sub-word stores
- memWrite  output  1  write strobe to data memory
- memRead  output  1  read strobe to data memory
- address  output  32  word index to memory = {2'b00, latched byte_addr[31:2]}
- writedata  output  32  word written to memory
- readdata  input  32  word returned by memory (combinational read)
- load_data  output  32  extended load result, valid while done=1, held afterwards
- stall  output  1  hold the pipeline
- done  output  1  one-cycle completion pulse
- misaligned  output  1  one-cycle fault pulse: half with addr[0]=1, or word with addr[1:0]!=0
- bad_addr  output  1  one-cycle fault pulse: byte_addr[31:2] >= MEM_WORDS

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE.
  - memWrite, memRead, done, misaligned, bad_addr = 0.
  - address, writedata, load_data = 0.
  - Internal latches (addr, size, unsigned flag, store data, word buffer) = 0.
- Request: req = MemRead | MemWrite. If both are high, it is a store (MemWrite wins).
- States: IDLE, RD, WR, DONE.
- Fault check (IDLE with req): misaligned takes priority over bad_addr.
  - If either fault applies: pulse misaligned or bad_addr for that cycle.
  - No memory strobe, stall=0, remain in IDLE.
- IDLE with valid req:
  - Latch byte_addr, mem_size, mem_unsigned, store_data.
  - Word store -> WR; any load or sub-word store -> RD.
- RD:
  - memRead=1, address = latched word index.
  - At the clock edge, capture readdata into the word buffer.
  - Load -> DONE; sub-word store -> WR.
- WR:
  - memWrite=1.
  - writedata = store_data for a word store.
  - For a sub-word store, writedata = buffer with the target lane replaced:
    - Byte lane k = addr[1:0], bits [8k+7:8k] <- store_data[7:0].
    - Halfword lane addr[1], bits [16h+15:16h] <- store_data[15:0].
  - -> DONE.
- DONE:
  - stall=0, done=1, load_data valid for loads.
  - -> IDLE unconditionally. The request visible in DONE is the same instruction and is not reissued.
- Stall: stall = (IDLE & valid req & no fault) | RD | WR. stall is combinational from state and inputs.
- Strobes and bus:
  - memRead and memWrite are decoded from state only, never both high, each high for exactly one cycle per access.
  - address and writedata are stable for the whole strobe cycle.
  - Outside RD/WR, address holds its last value and both strobes are 0.
- Load extraction is little-endian:
  - Byte k = buffer[8k+7:8k].
  - Half h = buffer[16h+15:16h].
  - Sign- or zero-extend to 32 bits per the latched mem_unsigned.
  - A word load returns the buffer unchanged.
- Latency (request cycle through DONE inclusive):
  - Word load: 3 cycles.
  - Word store: 3 cycles.
  - Sub-word load: 3 cycles.
  - Sub-word store: 4 cycles.
  - Stall cycles = latency - 1.
- Inputs changing after IDLE are ignored; the latched values are used.
- Reset mid-operation: state returns to IDLE at that edge, all strobes low from the next cycle. A pending WR is abandoned with no memory write. done does not pulse.
- Back-to-back requests: a new request can be accepted in the IDLE cycle immediately after DONE.

Test Plan:
- Reset, then word store byte_addr=0x10, store_data=0xDEADBEEF.
  - Required: stall 1,1,0; memWrite=1 in cycle 2 only, address=4, writedata=0xDEADBEEF; done in cycle 3.
  - Then word load 0x10 -> memRead=1 one cycle; load_data=0xDEADBEEF at done.
- Memory word 3 = 0x80FF7F01. Byte loads at 0x0C..0x0F:
  - Signed -> 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80.
  - Unsigned at 0x0F -> 0x00000080.
- Memory word 2 = 0x11223344. Byte store 0xAB at 0x09:
  - Required: memRead in cycle 2, then memWrite in cycle 3 with writedata=0x1122AB44; 4-cycle latency.
  - Then halfword store 0xCAFE at 0x0A -> 0xCAFEAB44.
- Word load at 0x06 -> misaligned=1 for one cycle, stall=0, no strobes.
- With MEM_WORDS=32, word load at 0x80 -> bad_addr=1, no strobes.
- Both MemRead and MemWrite high -> treated as a store.
- Assert reset during the RD cycle of a sub-word store -> no memWrite ever occurs, done stays 0, state returns to IDLE, memory word unchanged.
